// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control unit: opcodes, FSM states,
// datapath mux selects and the per-state control word decode.
package mips_pkg;

   typedef enum logic [5:0] {
      OP_R    = 6'b000000,
      OP_LW   = 6'b100011,
      OP_SW   = 6'b101011,
      OP_BEQ  = 6'b000100,
      OP_J    = 6'b000010,
      OP_ADDI = 6'b001000
   } opcode_t;

   typedef enum logic [3:0] {
      S_RESET, S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE,
      S_R_EXEC, S_R_WB, S_ADDI_EXEC, S_ADDI_WB, S_BEQ, S_JUMP, S_HALT
   } state_t;

   localparam logic [1:0] ULA_ADD   = 2'b00;
   localparam logic [1:0] ULA_SUB   = 2'b01;
   localparam logic [1:0] ULA_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_B      = 2'b00;
   localparam logic [1:0] SRCB_4      = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH = 2'b11;

   localparam logic [1:0] PCSRC_ULA    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       ula_src_a;
      logic [1:0] ula_src_b;
      logic [1:0] pc_source;
      logic [1:0] ula_op;
   } ctrl_t;

   // ultimo: the wait counter sits on the final memory cycle of this state
   function automatic ctrl_t decodifica(state_t s, logic ultimo);
      ctrl_t c;
      c = '0;
      case (s)
         S_FETCH: begin
            c.mem_read  = 1'b1;
            c.ula_src_b = SRCB_4;
            c.ula_op    = ULA_ADD;
            c.pc_source = PCSRC_ULA;
            c.ir_write  = ultimo;
            c.pc_write  = ultimo;
         end
         S_DECODE:    c.ula_src_b = SRCB_IMM_SH;
         S_MEM_ADDR: begin
            c.ula_src_a = 1'b1;
            c.ula_src_b = SRCB_IMM;
         end
         S_MEM_READ: begin
            c.mem_read = 1'b1;
            c.iord     = 1'b1;
         end
         S_MEM_WB: begin
            c.reg_write  = 1'b1;
            c.mem_to_reg = 1'b1;
         end
         S_MEM_WRITE: begin
            c.mem_write = 1'b1;
            c.iord      = 1'b1;
         end
         S_R_EXEC: begin
            c.ula_src_a = 1'b1;
            c.ula_src_b = SRCB_B;
            c.ula_op    = ULA_FUNCT;
         end
         S_R_WB: begin
            c.reg_write = 1'b1;
            c.reg_dst   = 1'b1;
         end
         S_ADDI_EXEC: begin
            c.ula_src_a = 1'b1;
            c.ula_src_b = SRCB_IMM;
         end
         S_ADDI_WB:   c.reg_write = 1'b1;
         S_BEQ: begin
            c.ula_src_a     = 1'b1;
            c.ula_op        = ULA_SUB;
            c.pc_write_cond = 1'b1;
            c.pc_source     = PCSRC_ALUOUT;
         end
         S_JUMP: begin
            c.pc_write  = 1'b1;
            c.pc_source = PCSRC_JUMP;
         end
         default: ;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/contador_espera.sv
// Memory wait counter: counts 0..MEM_LAT-1 while enabled, clear has priority.
// done_d_o looks one cycle ahead so the FSM can register its outputs.
module contador_espera #(
   parameter int MEM_LAT = 2
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clear_i,
   input  logic enable_i,
   output logic done_o,
   output logic done_d_o
);

   localparam int            CW     = $clog2(MEM_LAT + 1);
   localparam logic [CW-1:0] ULTIMO = CW'(MEM_LAT - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i)       cnt_d = '0;
      else if (enable_i) cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) cnt_q <= '0;
      else          cnt_q <= cnt_d;
   end

   assign done_o   = (cnt_q == ULTIMO);
   assign done_d_o = (cnt_d == ULTIMO);

endmodule

// File: rtl/unidade_controle_multiciclo.sv
// Multicycle MIPS control FSM (Moore) with registered control outputs,
// stalling on a fixed-latency memory through contador_espera.
module unidade_controle_multiciclo
   import mips_pkg::*;
#(
   parameter int MEM_LAT = 2
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [5:0] opcode,
   input  logic       zero,
   output logic       PCWrite,
   output logic       PCWriteCond,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       MemtoReg,
   output logic       RegDst,
   output logic       RegWrite,
   output logic       ULASrcA,
   output logic [1:0] ULASrcB,
   output logic [1:0] PCSource,
   output logic [1:0] ULAOp,
   output logic       excecao
);

   state_t state_q, state_d;
   ctrl_t  ctrl_q;
   logic   excecao_q;
   logic   espera, done, ultimo_d;
   logic   zero_unused;

   // zero only gates PCWriteCond inside the datapath
   assign zero_unused = zero;

   assign espera = (state_q == S_FETCH) || (state_q == S_MEM_READ) || (state_q == S_MEM_WRITE);

   // counter is cleared on leaving a wait state and held at 0 everywhere else
   contador_espera #(.MEM_LAT(MEM_LAT)) u_espera (
      .clk     (clk),
      .reset_n (reset_n),
      .clear_i (done | ~espera),
      .enable_i(espera),
      .done_o  (done),
      .done_d_o(ultimo_d)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_RESET:     state_d = S_FETCH;
         S_FETCH:     if (done) state_d = S_DECODE;
         S_DECODE: begin
            case (opcode_t'(opcode))
               OP_R:         state_d = S_R_EXEC;
               OP_LW, OP_SW: state_d = S_MEM_ADDR;
               OP_BEQ:       state_d = S_BEQ;
               OP_J:         state_d = S_JUMP;
               OP_ADDI:      state_d = S_ADDI_EXEC;
               default:      state_d = S_HALT;
            endcase
         end
         S_MEM_ADDR:  state_d = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
         S_MEM_READ:  if (done) state_d = S_MEM_WB;
         S_MEM_WRITE: if (done) state_d = S_FETCH;
         S_MEM_WB, S_R_WB, S_ADDI_WB, S_BEQ, S_JUMP: state_d = S_FETCH;
         S_R_EXEC:    state_d = S_R_WB;
         S_ADDI_EXEC: state_d = S_ADDI_WB;
         S_HALT:      state_d = S_HALT;
         default:     state_d = S_FETCH;
      endcase
   end

   // outputs are decoded from the next state so they line up with state_q
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_RESET;
         ctrl_q    <= '0;
         excecao_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ctrl_q    <= decodifica(state_d, ultimo_d);
         excecao_q <= excecao_q | (state_d == S_HALT);
      end
   end

   assign PCWrite     = ctrl_q.pc_write;
   assign PCWriteCond = ctrl_q.pc_write_cond;
   assign IorD        = ctrl_q.iord;
   assign MemRead     = ctrl_q.mem_read;
   assign MemWrite    = ctrl_q.mem_write;
   assign IRWrite     = ctrl_q.ir_write;
   assign MemtoReg    = ctrl_q.mem_to_reg;
   assign RegDst      = ctrl_q.reg_dst;
   assign RegWrite    = ctrl_q.reg_write;
   assign ULASrcA     = ctrl_q.ula_src_a;
   assign ULASrcB     = ctrl_q.ula_src_b;
   assign PCSource    = ctrl_q.pc_source;
   assign ULAOp       = ctrl_q.ula_op;
   assign excecao     = excecao_q;

endmodule

// File: tb/tb_unidade_controle_multiciclo.sv
// Scoreboard bench: two DUTs (MEM_LAT 2 and 3) driven with random instruction
// streams; expected per-cycle control words come from a cycle-index model.
module tb_unidade_controle_multiciclo;

   typedef struct packed {
      logic [5:0]  op;
      logic [7:0]  idx;
      logic [16:0] v;
   } exp_t;

   logic        clk;
   logic [1:0]  rst_n;
   logic [1:0]  zer;
   logic [5:0]  opc [2];
   logic [1:0]  pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, sa, exc;
   logic [1:0]  srcb [2];
   logic [1:0]  pcs  [2];
   logic [1:0]  ulop [2];
   logic [16:0] obs  [2];

   exp_t q0[$];
   exp_t q1[$];
   int   checks   = 0;
   int   failures = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      unidade_controle_multiciclo #(.MEM_LAT(g == 0 ? 2 : 3)) u_dut (
         .clk        (clk),
         .reset_n    (rst_n[g]),
         .opcode     (opc[g]),
         .zero       (zer[g]),
         .PCWrite    (pcw[g]),
         .PCWriteCond(pcwc[g]),
         .IorD       (iord[g]),
         .MemRead    (mr[g]),
         .MemWrite   (mw[g]),
         .IRWrite    (irw[g]),
         .MemtoReg   (m2r[g]),
         .RegDst     (rdst[g]),
         .RegWrite   (rw[g]),
         .ULASrcA    (sa[g]),
         .ULASrcB    (srcb[g]),
         .PCSource   (pcs[g]),
         .ULAOp      (ulop[g]),
         .excecao    (exc[g])
      );
      assign obs[g] = {exc[g], pcw[g], pcwc[g], iord[g], mr[g], mw[g], irw[g], m2r[g],
                       rdst[g], rw[g], sa[g], srcb[g], pcs[g], ulop[g]};
   end

   function automatic logic [16:0] cv(bit pw, bit pwc, bit io, bit rd, bit wr, bit ir,
                                      bit mtr, bit dst, bit rgw, bit a,
                                      bit [1:0] b, bit [1:0] ps, bit [1:0] op);
      return {1'b0, pw, pwc, io, rd, wr, ir, mtr, dst, rgw, a, b, ps, op};
   endfunction

   function automatic bit valido(logic [5:0] op);
      return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};
   endfunction

   // cycles from first fetch cycle to last cycle before the next fetch
   function automatic int nciclos(int lat, logic [5:0] op, int nhalt);
      case (op)
         6'b000000, 6'b001000: return lat + 3;
         6'b100011:            return 2 * lat + 3;
         6'b101011:            return 2 * lat + 2;
         6'b000100, 6'b000010: return lat + 2;
         default:              return lat + 1 + nhalt;
      endcase
   endfunction

   // expected control word in cycle i of an instruction
   function automatic logic [16:0] esperado(int lat, logic [5:0] op, int i);
      int j;
      bit last;
      last = (i == lat - 1);
      if (i < lat)  return cv(last, 0, 0, 1, 0, last, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00);
      if (i == lat) return cv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00);
      j = i - lat - 1;
      case (op)
         6'b000000: return (j == 0) ? cv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b10)
                                    : cv(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00);
         6'b001000: return (j == 0) ? cv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00)
                                    : cv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00);
         6'b100011: begin
            if (j == 0)   return cv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00);
            if (j <= lat) return cv(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
            return cv(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00);
         end
         6'b101011: return (j == 0) ? cv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00)
                                    : cv(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
         6'b000100: return cv(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 2'b01);
         6'b000010: return cv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00);
         default:   return 17'h10000;
      endcase
   endfunction

   task automatic push(input int k, input logic [5:0] op, input int idx, input logic [16:0] v);
      exp_t e;
      e.op  = op;
      e.idx = 8'(idx);
      e.v   = v;
      if (k == 0) q0.push_back(e);
      else        q1.push_back(e);
   endtask

   task automatic compara(input int k, input exp_t e);
      checks++;
      if (obs[k] !== e.v) begin
         failures++;
         $display("FAIL ctl dut%0d op=%b cyc=%0d got=%h exp=%h", k, e.op, e.idx, obs[k], e.v);
      end
   endtask

   // monitor: one expected word per cycle, sampled on the falling edge
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q0.size() > 0) begin e = q0.pop_front(); compara(0, e); end
         if (q1.size() > 0) begin e = q1.pop_front(); compara(1, e); end
      end
   end

   // reset pulse spanning one cycle without a rising edge; outputs must be all zero
   task automatic pulso_reset(input int k);
      @(posedge clk);
      #2;
      rst_n[k] = 1'b0;
      push(k, 6'b0, 255, 17'h0);
      @(negedge clk);
      #2;
      rst_n[k] = 1'b1;
   endtask

   task automatic executa(input int k, input logic [5:0] op, input int abort_at,
                          input int nhalt, input bit z);
      int lat, n, lim;
      lat = (k == 0) ? 2 : 3;
      n   = nciclos(lat, op, nhalt);
      lim = (abort_at >= 0 && abort_at < n) ? abort_at : n;
      opc[k] = op;
      zer[k] = z;
      for (int i = 0; i < lim; i++) push(k, op, i, esperado(lat, op, i));
      if (lim > 0) begin
         repeat (lim) @(posedge clk);
         #2;
      end
      if (lim < n || !valido(op)) pulso_reset(k);
   endtask

   task automatic drv(input int k);
      int lat, r, nh, n, ab;
      logic [5:0] op;
      lat = (k == 0) ? 2 : 3;
      pulso_reset(k);
      executa(k, 6'b000000, -1, 0, 0);
      executa(k, 6'b100011, -1, 0, 1);
      executa(k, 6'b101011, -1, 0, 0);
      executa(k, 6'b000100, -1, 0, 0);
      executa(k, 6'b000100, -1, 0, 1);
      executa(k, 6'b000010, -1, 0, 0);
      executa(k, 6'b001000, -1, 0, 1);
      executa(k, 6'b111111, -1, 20, 0);
      executa(k, 6'b100011, lat + 2, 0, 0);
      executa(k, 6'b000000, -1, 0, 0);
      repeat (40) begin
         r  = $urandom_range(0, 11);
         nh = 0;
         case (r)
            0, 1:    op = 6'b000000;
            2, 3:    op = 6'b100011;
            4, 5:    op = 6'b101011;
            6:       op = 6'b000100;
            7:       op = 6'b000010;
            8, 9:    op = 6'b001000;
            default: begin
               op = 6'(($urandom) % 64);
               while (valido(op)) op = 6'(($urandom) % 64);
               nh = $urandom_range(1, 6);
            end
         endcase
         n  = nciclos(lat, op, nh);
         ab = ($urandom_range(0, 7) == 0) ? $urandom_range(0, n - 1) : -1;
         executa(k, op, ab, nh, 1'($urandom));
      end
   endtask

   initial begin
      rst_n  = 2'b00;
      zer    = 2'b00;
      opc[0] = 6'b0;
      opc[1] = 6'b0;
      fork
         drv(0);
         drv(1);
      join
      repeat (3) @(negedge clk);
      checks++;
      if (q0.size() != 0 || q1.size() != 0) begin
         failures++;
         $display("FAIL drain q0=%0d q1=%0d required=0", q0.size(), q1.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog time limit reached checks=%0d", checks);
      $fatal(1, "watchdog");
   end

endmodule
